// File: rtl/tt_um_chip_sp_receptor_mensaje.sv
// Receive side of the ASCII message path: frames terminator-ended messages and
// reports length, XOR checksum, word count and status flags on the display bus.
module tt_um_chip_sp_receptor_mensaje #(
  parameter logic [7:0] TERM_CHAR = 8'h3B,
  parameter logic [7:0] MAX_LEN   = 8'd255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [7:0] run_len, run_chk, run_words;
  logic [7:0] res_len, res_chk, res_words;
  logic       prev_space, overflow, error, done;
  logic [7:0] uo_next;

  logic       valid, clr;
  logic [1:0] sel;
  logic       is_term, is_space, bad_char, busy;
  logic       unused_bits;

  assign valid       = uio_in[0];
  assign sel         = uio_in[2:1];
  assign clr         = uio_in[3];
  assign unused_bits = &{1'b0, uio_in[7:4]};

  assign is_term  = (ui_in == TERM_CHAR);
  assign is_space = (ui_in == 8'h20);
  assign bad_char = (ui_in < 8'h20) || (ui_in > 8'h7E);
  assign busy     = (state == RECV);

  assign uio_out = {overflow, error, done, busy, 4'b0000};
  assign uio_oe  = 8'hF0;

  always_comb begin
    uo_next = '0;
    case (sel)
      2'b00:   uo_next = res_len;
      2'b01:   uo_next = res_chk;
      2'b10:   uo_next = res_words;
      default: uo_next = {4'b0000, overflow, error, done, busy};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_len    <= '0;
      run_chk    <= '0;
      run_words  <= '0;
      res_len    <= '0;
      res_chk    <= '0;
      res_words  <= '0;
      prev_space <= 1'b1;
      overflow   <= 1'b0;
      error      <= 1'b0;
      done       <= 1'b0;
      uo_out     <= '0;
    end else begin
      uo_out <= uo_next;
      if (ena) begin
        if (clr) begin
          state      <= IDLE;
          run_len    <= '0;
          run_chk    <= '0;
          run_words  <= '0;
          res_len    <= '0;
          res_chk    <= '0;
          res_words  <= '0;
          prev_space <= 1'b1;
          overflow   <= 1'b0;
          error      <= 1'b0;
          done       <= 1'b0;
        end else if (valid) begin
          if (state == RECV) begin
            if (is_term) begin
              res_len   <= run_len;
              res_chk   <= run_chk;
              res_words <= run_words;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              run_chk <= run_chk ^ ui_in;
              if (run_len == MAX_LEN) overflow <= 1'b1;
              else                    run_len  <= run_len + 8'd1;
              // A word starts on the first non-space after a space.
              if (prev_space && !is_space && (run_words != MAX_LEN))
                run_words <= run_words + 8'd1;
              prev_space <= is_space;
              if (bad_char) error <= 1'b1;
            end
          end else if (!is_term) begin
            // IDLE and DONE both open a new frame on a non-terminator.
            state      <= RECV;
            run_len    <= 8'd1;
            run_chk    <= ui_in;
            run_words  <= {7'b0, !is_space};
            prev_space <= is_space;
            error      <= bad_char;
            overflow   <= 1'b0;
            done       <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_chip_sp_receptor_mensaje.sv
// Bench for the message receiver: directed vector table, hand sequences for
// multi-cycle corners, and random traffic against a frame-level model.
module tb_tt_um_chip_sp_receptor_mensaje;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  tt_um_chip_sp_receptor_mensaje #(.TERM_CHAR(8'h3B), .MAX_LEN(8'd255)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  // Frame-level reference model: bytes of the open frame plus latched results.
  logic [7:0] q[$];
  bit         m_in;
  logic [7:0] m_len, m_chk, m_words;
  bit         m_ovf, m_err, m_done;

  function automatic logic [7:0] sat(input int n);
    return (n > 255) ? 8'd255 : n[7:0];
  endfunction

  function automatic logic [7:0] q_chk();
    logic [7:0] c = '0;
    foreach (q[i]) c ^= q[i];
    return c;
  endfunction

  function automatic logic [7:0] q_words();
    int n = 0;
    bit after_space = 1'b1;
    foreach (q[i]) begin
      if (q[i] != 8'h20 && after_space) n++;
      after_space = (q[i] == 8'h20);
    end
    return sat(n);
  endfunction

  function automatic logic [7:0] m_flags();
    return {m_ovf, m_err, m_done, m_in, 4'b0000};
  endfunction

  task automatic model_reset();
    q.delete();
    m_in = 0; m_len = '0; m_chk = '0; m_words = '0;
    m_ovf = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input bit c, input logic [7:0] d);
    if (!e) return;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (d == 8'h3B) begin
        if (m_in) begin
          m_len = sat(q.size()); m_chk = q_chk(); m_words = q_words();
          m_done = 1; m_in = 0;
        end
      end else begin
        if (!m_in) begin
          q.delete(); m_in = 1; m_done = 0; m_err = 0;
        end
        q.push_back(d);
        m_ovf = (q.size() > 255);
        if (d < 8'h20 || d > 8'h7E) m_err = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // One clock: predict display from pre-edge model state, drive, clock, compare.
  task automatic run(input bit e, input bit v, input bit c, input logic [1:0] s,
                     input logic [7:0] d);
    logic [7:0] exp_uo;
    case (s)
      2'b00:   exp_uo = m_len;
      2'b01:   exp_uo = m_chk;
      2'b10:   exp_uo = m_words;
      default: exp_uo = {4'b0000, m_ovf, m_err, m_done, m_in};
    endcase
    ena = e; uio_in = {4'b0000, c, s, v}; ui_in = d;
    @(posedge clk); #1;
    model_step(e, v, c, d);
    check("model_uo", uo_out, exp_uo);
    check("model_flags", uio_out, m_flags());
  endtask

  task automatic idle(input logic [1:0] s);
    run(1, 0, 0, s, 8'h00);
  endtask

  task automatic send(input string str);
    for (int i = 0; i < str.len(); i++) run(1, 1, 0, 2'b00, str[i]);
  endtask

  task automatic do_reset();
    rst_n = 0; ena = 0; uio_in = '0; ui_in = '0;
    #3;
    model_reset();
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  typedef struct {
    bit         e, v, c;
    logic [1:0] s;
    logic [7:0] d, exp_uo, exp_uio;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // "Hi;" then select sweep, then "a b;" with valid gaps.
    tbl[0]  = '{1, 1, 0, 2'b00, 8'h48, 8'h00, 8'h10};
    tbl[1]  = '{1, 1, 0, 2'b00, 8'h69, 8'h00, 8'h10};
    tbl[2]  = '{1, 1, 0, 2'b00, 8'h3B, 8'h00, 8'h20};
    tbl[3]  = '{1, 0, 0, 2'b00, 8'h00, 8'h02, 8'h20};
    tbl[4]  = '{1, 0, 0, 2'b01, 8'h00, 8'h21, 8'h20};
    tbl[5]  = '{1, 0, 0, 2'b10, 8'h00, 8'h01, 8'h20};
    tbl[6]  = '{1, 0, 0, 2'b11, 8'h00, 8'h02, 8'h20};
    tbl[7]  = '{1, 1, 0, 2'b00, 8'h61, 8'h02, 8'h10};
    tbl[8]  = '{1, 0, 0, 2'b00, 8'h20, 8'h02, 8'h10};
    tbl[9]  = '{1, 1, 0, 2'b00, 8'h20, 8'h02, 8'h10};
    tbl[10] = '{1, 0, 0, 2'b00, 8'h62, 8'h02, 8'h10};
    tbl[11] = '{1, 1, 0, 2'b00, 8'h62, 8'h02, 8'h10};
    tbl[12] = '{1, 1, 0, 2'b00, 8'h3B, 8'h02, 8'h20};
    tbl[13] = '{1, 0, 0, 2'b00, 8'h00, 8'h03, 8'h20};
    tbl[14] = '{1, 0, 0, 2'b01, 8'h00, 8'h23, 8'h20};
    tbl[15] = '{1, 0, 0, 2'b10, 8'h00, 8'h02, 8'h20};

    do_reset();
    check("uio_oe", uio_oe, 8'hF0);
    foreach (tbl[i]) begin
      ena = tbl[i].e; uio_in = {4'b0000, tbl[i].c, tbl[i].s, tbl[i].v}; ui_in = tbl[i].d;
      @(posedge clk); #1;
      model_step(tbl[i].e, tbl[i].v, tbl[i].c, tbl[i].d);
      check($sformatf("tbl%0d_uo", i), uo_out, tbl[i].exp_uo);
      check($sformatf("tbl%0d_uio", i), uio_out, tbl[i].exp_uio);
    end

    // Non-printable byte, then a clean frame clears the error.
    do_reset();
    run(1, 1, 0, 2'b00, 8'hE1);
    send(";");
    check("err_flags", uio_out, 8'h60);
    idle(2'b00); check("err_len", uo_out, 8'h01);
    idle(2'b01); check("err_chk", uo_out, 8'hE1);
    run(1, 1, 0, 2'b00, "o");
    check("ok_err_cleared", uio_out, 8'h10);
    send("k;");
    idle(2'b00); check("ok_len", uo_out, 8'h02);
    idle(2'b01); check("ok_chk", uo_out, 8'h04);
    idle(2'b10); check("ok_words", uo_out, 8'h01);

    // Length saturation.
    do_reset();
    for (int i = 0; i < 256; i++) run(1, 1, 0, 2'b00, 8'h61);
    send(";");
    check("ovf_flags", uio_out, 8'hA0);
    idle(2'b11); check("ovf_sel11", uo_out, 8'h0A);
    idle(2'b00); check("ovf_len", uo_out, 8'hFF);
    idle(2'b01); check("ovf_chk", uo_out, 8'h00);
    idle(2'b10); check("ovf_words", uo_out, 8'h01);

    // Empty frames are dropped; ena low ignores a byte.
    do_reset();
    send(";;");
    check("empty_flags", uio_out, 8'h00);
    idle(2'b00); check("empty_len", uo_out, 8'h00);
    send("x;");
    idle(2'b00); check("x_len", uo_out, 8'h01);
    idle(2'b01); check("x_chk", uo_out, 8'h78);
    run(0, 1, 0, 2'b01, "x");
    send(";");
    check("ena_flags", uio_out, 8'h20);
    idle(2'b00); check("ena_len", uo_out, 8'h01);
    idle(2'b01); check("ena_chk", uo_out, 8'h78);

    // Asynchronous reset mid-frame, then a stray terminator.
    send("ab");
    @(negedge clk);
    do_reset();
    send(";");
    check("rst_flags", uio_out, 8'h00);
    idle(2'b00); check("rst_len", uo_out, 8'h00);
    idle(2'b11); check("rst_sel11", uo_out, 8'h00);

    // Clear beats a simultaneous valid byte.
    send("Hi;");
    run(1, 1, 1, 2'b00, "q");
    check("clr_flags", uio_out, 8'h00);
    idle(2'b00); check("clr_len", uo_out, 8'h00);
    idle(2'b01); check("clr_chk", uo_out, 8'h00);
    idle(2'b10); check("clr_words", uo_out, 8'h00);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      int unsigned r = $urandom_range(0, 99);
      bit e = ($urandom_range(0, 9) != 0);
      bit v = ($urandom_range(0, 3) != 0);
      bit c = e && ($urandom_range(0, 99) < 2);
      if (r < 15)      d = 8'h3B;
      else if (r < 35) d = 8'h20;
      else if (r < 90) d = 8'($urandom_range(8'h61, 8'h7A));
      else             d = 8'($urandom);
      run(e, v, c, 2'($urandom), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
